// File: rtl/div_if.sv
// Handshake and data bundle between a divider client and div_unit.
interface div_if;
    logic        DIV_START;
    logic [31:0] DIV_DA;
    logic [31:0] DIV_DB;
    logic [1:0]  DIV_CTL;
    logic        DIV_FLUSH;
    logic        DIV_BUSY;
    logic        DIV_DONE;
    logic [31:0] DIV_DC;

    modport master (
        output DIV_START, DIV_DA, DIV_DB, DIV_CTL, DIV_FLUSH,
        input  DIV_BUSY, DIV_DONE, DIV_DC
    );

    modport slave (
        input  DIV_START, DIV_DA, DIV_DB, DIV_CTL, DIV_FLUSH,
        output DIV_BUSY, DIV_DONE, DIV_DC
    );
endinterface

// File: rtl/div_unit.sv
// 32-bit iterative restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Optional macro DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow finish in one cycle.
module div_unit (
    input logic  clk,
    input logic  rst_n,
    div_if.slave bus
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_divisor;
    logic [31:0] r_result;
    logic [4:0]  r_count;
    logic        r_remSel;
    logic        r_quoNeg;
    logic        r_remNeg;
    logic        r_divZero;

    logic        w_accept;
    logic        w_signedOp;
    logic        w_divZero;
    logic        w_fast;
    logic [31:0] w_absA;
    logic [31:0] w_absB;
    logic [31:0] w_fastResult;
    logic [32:0] w_partial;
    logic [33:0] w_diff;
    logic        w_borrow;
    logic [31:0] w_quoFinal;
    logic [31:0] w_remFinal;

    assign w_accept   = bus.DIV_START && !bus.DIV_FLUSH && (r_state == IDLE || r_state == DONE);
    assign w_signedOp = ~bus.DIV_CTL[0];
    assign w_divZero  = (bus.DIV_DB == 32'd0);
    assign w_absA     = (w_signedOp && bus.DIV_DA[31]) ? -bus.DIV_DA : bus.DIV_DA;
    assign w_absB     = (w_signedOp && bus.DIV_DB[31]) ? -bus.DIV_DB : bus.DIV_DB;

`ifdef DIV_FAST_SPECIAL_EN
    logic w_overflow;
    assign w_overflow   = w_signedOp && (bus.DIV_DA == 32'h8000_0000) && (bus.DIV_DB == 32'hFFFF_FFFF);
    assign w_fast       = w_divZero || w_overflow;
    assign w_fastResult = bus.DIV_CTL[1] ? (w_divZero ? bus.DIV_DA : 32'd0)
                                         : (w_divZero ? 32'hFFFF_FFFF : 32'h8000_0000);
`else
    assign w_fast       = 1'b0;
    assign w_fastResult = 32'd0;
`endif

    // Extra borrow bit above the 33-bit partial remainder keeps the compare exact.
    assign w_partial  = {r_rem, r_quo[31]};
    assign w_diff     = {1'b0, w_partial} - {2'b00, r_divisor};
    assign w_borrow   = w_diff[33];

    assign w_quoFinal = r_divZero ? 32'hFFFF_FFFF : (r_quoNeg ? -r_quo : r_quo);
    assign w_remFinal = r_remNeg ? -r_rem : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.DIV_FLUSH) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        w_nextState = w_fast ? DONE : CALC;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
                CALC:    w_nextState = (r_count == 5'd0) ? FIX : CALC;
                FIX:     w_nextState = DONE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo     <= 32'd0;
            r_rem     <= 32'd0;
            r_divisor <= 32'd0;
            r_result  <= 32'd0;
            r_count   <= 5'd0;
            r_remSel  <= 1'b0;
            r_quoNeg  <= 1'b0;
            r_remNeg  <= 1'b0;
            r_divZero <= 1'b0;
        end else if (w_accept) begin
            r_quo     <= w_absA;
            r_rem     <= 32'd0;
            r_divisor <= w_absB;
            r_count   <= 5'd31;
            r_remSel  <= bus.DIV_CTL[1];
            r_quoNeg  <= w_signedOp && (bus.DIV_DA[31] ^ bus.DIV_DB[31]);
            r_remNeg  <= w_signedOp && bus.DIV_DA[31];
            r_divZero <= w_divZero;
            if (w_fast) begin
                r_result <= w_fastResult;
            end
        end else if (r_state == CALC) begin
            r_quo   <= {r_quo[30:0], ~w_borrow};
            r_rem   <= w_borrow ? w_partial[31:0] : w_diff[31:0];
            r_count <= r_count - 5'd1;
        end else if (r_state == FIX && !bus.DIV_FLUSH) begin
            r_result <= r_remSel ? w_remFinal : w_quoFinal;
        end
    end

    assign bus.DIV_BUSY = (r_state == CALC) || (r_state == FIX);
    assign bus.DIV_DONE = (r_state == DONE);
    assign bus.DIV_DC   = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_div_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [31:0] lastResult;

    div_if bus ();

    div_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic isSpecial(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!ctl[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] refModel(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!ctl[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!ctl[0]) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return ctl[1] ? r : q;
    endfunction

    function automatic int expLatency(input logic [1:0] ctl, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_FAST_SPECIAL_EN
        return isSpecial(ctl, a, b) ? 1 : 34;
`else
        return (isSpecial(ctl, a, b) != 1'b0) ? 34 : 34;
`endif
    endfunction

    // Launch one op, scramble operands while it runs, optionally try a second start
    // at cycle intrudeAt, then check latency, busy time and result.
    task automatic applyStimulus(input string tag, input logic [1:0] ctl, input logic [31:0] a,
                                 input logic [31:0] b, input int intrudeAt, input bit noWait);
        int n;
        int busyCycles;
        int lat;
        logic [31:0] exp;
        lat = expLatency(ctl, a, b);
        exp = refModel(ctl, a, b);
        if (!noWait) @(negedge clk);
        bus.DIV_START = 1'b1;
        bus.DIV_CTL   = ctl;
        bus.DIV_DA    = a;
        bus.DIV_DB    = b;
        @(posedge clk);
        @(negedge clk);
        bus.DIV_START = 1'b0;
        n = 1;
        busyCycles = 0;
        while (!bus.DIV_DONE && n < 40) begin
            if (bus.DIV_BUSY) busyCycles++;
            bus.DIV_START = (n == intrudeAt);
            bus.DIV_CTL   = (n == intrudeAt) ? 2'b01 : 2'($urandom);
            bus.DIV_DA    = (n == intrudeAt) ? 32'd50 : $urandom;
            bus.DIV_DB    = (n == intrudeAt) ? 32'd5 : $urandom;
            @(negedge clk);
            n++;
        end
        bus.DIV_START = 1'b0;
        checkOutput({tag, "_latency"}, 32'(n), 32'(lat));
        checkOutput({tag, "_busy"}, 32'(busyCycles), (lat == 34) ? 32'd33 : 32'd0);
        checkOutput({tag, "_result"}, bus.DIV_DC, exp);
        lastResult = exp;
    endtask

    task automatic watchNoDone(input string tag, input int cycles);
        int doneCount;
        doneCount = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.DIV_DONE) doneCount++;
        end
        checkOutput(tag, 32'(doneCount), 32'd0);
    endtask

    initial begin
        logic [1:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        checks        = 0;
        failures      = 0;
        lastResult    = 32'd0;
        rst_n         = 1'b0;
        bus.DIV_START = 1'b0;
        bus.DIV_FLUSH = 1'b0;
        bus.DIV_CTL   = 2'b00;
        bus.DIV_DA    = 32'd0;
        bus.DIV_DB    = 32'd0;

        #12;
        checkOutput("reset_busy", 32'(bus.DIV_BUSY), 32'd0);
        checkOutput("reset_done", 32'(bus.DIV_DONE), 32'd0);
        checkOutput("reset_dc", bus.DIV_DC, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("divu_100_7", 2'b01, 32'd100, 32'd7, 0, 1'b1);
        applyStimulus("remu_100_7", 2'b11, 32'd100, 32'd7, 0, 1'b0);
        applyStimulus("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        applyStimulus("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        applyStimulus("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        applyStimulus("divu_5_0", 2'b01, 32'd5, 32'd0, 0, 1'b0);
        applyStimulus("remu_5_0", 2'b11, 32'd5, 32'd0, 0, 1'b0);
        applyStimulus("div_neg_0", 2'b00, 32'hFFFF_FF00, 32'd0, 0, 1'b0);
        applyStimulus("rem_neg_0", 2'b10, 32'hFFFF_FF00, 32'd0, 0, 1'b0);
        applyStimulus("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);

        // Second start mid-CALC is ignored; a start in the DONE cycle is taken back-to-back.
        applyStimulus("ignored_start", 2'b01, 32'd100, 32'd7, 5, 1'b0);
        applyStimulus("b2b_start", 2'b01, 32'd50, 32'd5, 0, 1'b1);

        // Flush mid-CALC.
        @(negedge clk);
        bus.DIV_START = 1'b1;
        bus.DIV_CTL   = 2'b01;
        bus.DIV_DA    = 32'd100;
        bus.DIV_DB    = 32'd7;
        @(negedge clk);
        bus.DIV_START = 1'b0;
        repeat (9) @(negedge clk);
        bus.DIV_FLUSH = 1'b1;
        @(negedge clk);
        bus.DIV_FLUSH = 1'b0;
        checkOutput("flush_busy", 32'(bus.DIV_BUSY), 32'd0);
        checkOutput("flush_dc", bus.DIV_DC, lastResult);
        watchNoDone("flush_no_done", 40);
        applyStimulus("after_flush", 2'b01, 32'd9, 32'd3, 0, 1'b0);

        // Flush and start together: flush wins.
        @(negedge clk);
        bus.DIV_START = 1'b1;
        bus.DIV_FLUSH = 1'b1;
        bus.DIV_CTL   = 2'b01;
        bus.DIV_DA    = 32'd77;
        bus.DIV_DB    = 32'd0;
        @(negedge clk);
        bus.DIV_START = 1'b0;
        bus.DIV_FLUSH = 1'b0;
        checkOutput("flush_start_busy", 32'(bus.DIV_BUSY), 32'd0);
        watchNoDone("flush_start_no_done", 40);
        checkOutput("flush_start_dc", bus.DIV_DC, lastResult);

        for (int i = 0; i < 40; i++) begin
            rc = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3:       begin ra = $urandom_range(0, 1000); rb = $urandom_range(1, 1000); end
                default: rb = $urandom;
            endcase
            applyStimulus("random", rc, ra, rb, 0, 1'b0);
        end

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        bus.DIV_START = 1'b1;
        bus.DIV_CTL   = 2'b01;
        bus.DIV_DA    = 32'd100;
        bus.DIV_DB    = 32'd7;
        @(negedge clk);
        bus.DIV_START = 1'b0;
        repeat (19) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(bus.DIV_BUSY), 32'd0);
        checkOutput("midreset_done", 32'(bus.DIV_DONE), 32'd0);
        checkOutput("midreset_dc", bus.DIV_DC, 32'd0);
        lastResult = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        watchNoDone("midreset_no_done", 40);
        applyStimulus("after_reset", 2'b01, 32'd100, 32'd7, 0, 1'b0);

        // First start right at the edge following reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("first_edge", 2'b11, 32'd100, 32'd7, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have no parameters; data width fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 DIV_START  input  1  request pulse; operands and op sampled when accepted.
REQ-005 DIV_DA  input  32  dividend.
REQ-006 DIV_DB  input  32  divisor.
REQ-007 DIV_CTL  input  2  op select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 DIV_FLUSH  input  1  abort in-flight operation (pipeline kill).
REQ-009 DIV_BUSY  output  1  high while an operation is in progress (CALC, FIX).
REQ-010 DIV_DONE  output  1  one-cycle pulse: DIV_DC valid.
REQ-011 DIV_DC  output  32  result; held stable from DONE until next accepted start.

Function
REQ-012 States SHALL be IDLE, CALC, FIX, DONE; one-hot or binary encoding at implementer's choice.
REQ-013 DIV_START SHALL be accepted only when DIV_BUSY=0 (IDLE or DONE) and DIV_FLUSH=0; a start while busy is ignored.
REQ-014 On acceptance: latch op; signed ops (DIV, REM) take absolute values of DA/DB and record quotient sign (DA[31]^DB[31]) and remainder sign (DA[31]); go to CALC with iteration counter = 31.
REQ-015 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first, using a 33-bit partial-remainder subtract; counter decrements each cycle; exit to FIX after the counter-0 iteration (32 CALC cycles).
REQ-016 FIX SHALL negate quotient/remainder per recorded signs (signed ops only), select quotient (DIV, DIVU) or remainder (REM, REMU) into DIV_DC, go to DONE.
REQ-017 DONE SHALL assert DIV_DONE for exactly one cycle, then go to IDLE unless a start is accepted in that cycle (back-to-back, goes to CALC).
REQ-018 Latency: DIV_DONE SHALL be high exactly 34 cycles after the accepting clock edge (32 CALC + 1 FIX + DONE), except as in REQ-026.
REQ-019 Divide by zero: quotient SHALL be 0xFFFFFFFF (all ops), remainder SHALL equal original DA.
REQ-020 Signed overflow (DA=0x80000000, DB=0xFFFFFFFF, DIV/REM): quotient SHALL be 0x80000000, remainder 0.
REQ-021 DIV_FLUSH high in any state SHALL force IDLE at next edge; no DIV_DONE for the aborted op; DIV_DC retains previous value.
REQ-022 DIV_FLUSH and DIV_START in same cycle: flush wins, start dropped.
REQ-023 Operand inputs SHALL be ignored after acceptance; changes during CALC have no effect.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, DIV_BUSY=0, DIV_DONE=0, DIV_DC=0x00000000, clear all internal registers, regardless of state (including mid-CALC).
REQ-025 First start SHALL be accepted at the first rising edge with rst_n high.

Configuration
REQ-026 Macro DIV_FAST_SPECIAL_EN defined: divide-by-zero and signed-overflow cases SHALL skip CALC/FIX and go from acceptance directly to DONE (DIV_DONE high 1 cycle after accepting edge) with REQ-019/020 values; DIV_BUSY stays 0 for these ops.
REQ-027 Macro undefined: special cases SHALL take the full 34-cycle path and produce identical REQ-019/020 values.

Verification
REQ-028 DIVU 100/7 -> DIV_DC=14, DIV_DONE 34 cycles after start, BUSY high 33 cycles; REMU same operands -> 2.
REQ-029 DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-030 DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; latency 1 with DIV_FAST_SPECIAL_EN, 34 without.
REQ-031 Start DIVU 100/7, pulse DIV_FLUSH at cycle 10 -> no DONE, BUSY low next cycle, DC unchanged; new start DIVU 9/3 -> 3 after 34 cycles.
REQ-032 Start DIVU 100/7, second start with 50/5 at cycle 5 -> ignored, result 14; start 50/5 in DONE cycle -> accepted, result 10 after 34 more cycles.
REQ-033 Assert rst_n low at cycle 20 of DIVU 100/7 -> BUSY, DONE, DC all 0 asynchronously; no later DONE.
